hangman_game_ctrl: RTL and testbench
====================================

HANGMAN_GAME_CTRL -- requirements
Module: hangman_game_ctrl

Interface
REQ-001 The block SHALL have one parameter: MAX_MISSES, default 6, wrong guesses allowed before loss (legal range 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse that latches word_1..word_7 and begins a game.
REQ-005 The block SHALL have ports word_1..word_7, input, 7 bits each: the secret word, uppercase ASCII.
REQ-006 The block SHALL have port guess_valid, input, 1 bit: the guess strobe.
REQ-007 The block SHALL have port guess_letter, input, 7 bits: the guessed ASCII letter.
REQ-008 The block SHALL have port guess_ready, output, 1 bit: high only in PLAY.
REQ-009 The block SHALL have ports out_ascii_1..out_ascii_7, output, 7 bits each: the revealed letter or 0x2D ('-').
REQ-010 The block SHALL have port reveal_mask, output, 7 bits: bit i-1 set when word_i has been revealed.
REQ-011 The block SHALL have port miss_count, output, 3 bits: the wrong-guess count.
REQ-012 The block SHALL have ports hit, miss and guess_err, output, 1 bit each: one-cycle result pulses.
REQ-013 The block SHALL have ports win and lose, output, 1 bit each: levels that hold until start or rst.

Function
REQ-014 The FSM SHALL have states IDLE, PLAY, EVAL, WIN and LOSE.
REQ-015 IDLE SHALL move to PLAY on start, latching word_1..word_7 into internal registers in the same cycle.
REQ-016 In PLAY, guess_valid=1 SHALL register guess_letter and move to EVAL on that edge; guess_valid outside PLAY SHALL be ignored.
REQ-017 EVAL SHALL last exactly one cycle, comparing the registered guess with all 7 latched letters in parallel.
REQ-018 At the EVAL edge, every matching position SHALL be OR'd into reveal_mask; letters already revealed SHALL stay revealed.
REQ-019 If at least one match occurs, hit SHALL pulse, including when every matching position was already revealed.
REQ-020 If no match occurs, miss SHALL pulse and miss_count SHALL increment by 1, saturating at MAX_MISSES.
REQ-021 A guess outside 0x41..0x5A SHALL pulse guess_err only: no mask change, no miss, return to PLAY.
REQ-022 Pulse timing: for a guess accepted at edge N, hit, miss, guess_err, reveal_mask and miss_count SHALL be valid in the cycle after edge N+1.
REQ-023 After EVAL, the next state SHALL be WIN if reveal_mask==7'h7F, else LOSE if miss_count==MAX_MISSES, else PLAY.
REQ-024 WIN SHALL take priority over LOSE when both conditions are true in the same EVAL.
REQ-025 out_ascii_i SHALL equal the latched word_i when mask bit i-1 is set, else 7'h2D; it SHALL be driven from registers.
REQ-026 WIN and LOSE SHALL hold their outputs; start SHALL clear mask, misses, win and lose and re-enter PLAY with the new word.
REQ-027 start SHALL take priority over guess_valid in every state, aborting any game in progress including one in EVAL.
REQ-028 Word letters SHALL NOT be range-checked; a non-letter word position can never be revealed.

Reset
REQ-029 On rst=1 at a clock edge, the FSM SHALL enter IDLE and the block SHALL clear reveal_mask, miss_count, hit, miss, guess_err, win, lose and guess_ready.
REQ-030 On rst=1 at a clock edge, out_ascii_1..7 SHALL reset to 7'h2D and the latched word to 0.
REQ-031 rst SHALL take priority over start, including mid-game and during EVAL.

Configuration
REQ-032 Macro HANGMAN_REPEAT_DETECT_EN SHALL control repeated-guess handling.
REQ-033 With HANGMAN_REPEAT_DETECT_EN defined, a 26-bit guessed-letter bitmap SHALL be kept, cleared by rst and start.
REQ-034 With the bitmap present, a repeated letter SHALL pulse guess_err with no hit, no miss and no count change.
REQ-035 Without HANGMAN_REPEAT_DETECT_EN, no bitmap SHALL exist and repeated letters SHALL be evaluated normally.

Structure
REQ-036 Package hangman_pkg SHALL hold the state enum, ASCII_DASH=7'h2D, ASCII_A=7'h41, ASCII_Z=7'h5A and WORD_LEN=7.
REQ-037 Sub-module hangman_letter_match SHALL be combinational, taking 7 letters and a guess and returning a 7-bit match vector.

Verification
REQ-038 Bench SHALL check: start with "HANGMAN", guess 'A' -> hit, reveal_mask=7'b0100010, out_ascii_2=out_ascii_6=0x41, others 0x2D.
REQ-039 Bench SHALL check: guess H,N,G,M,A in sequence -> win=1 after the final EVAL, miss_count=0, guess_ready=0.
REQ-040 Bench SHALL check: six wrong letters with MAX_MISSES=6 -> lose=1 and miss_count=6; a seventh guess_valid is ignored.
REQ-041 Bench SHALL check: five misses, then a final-letter hit on the last hidden letter -> win=1, lose=0.
REQ-042 Bench SHALL check: guess 0x61 ('a') -> guess_err pulse only; with HANGMAN_REPEAT_DETECT_EN, repeat 'Q' -> the second 'Q' gives guess_err and miss_count is unchanged.
REQ-043 Bench SHALL check: rst, and separately start, asserted in EVAL -> IDLE with all outputs at reset values, and PLAY with a fresh mask, respectively.

Source files
------------

// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - shared types and constants for the hangman game controller
package hangman_pkg;

  localparam int WORD_LEN = 7;

  localparam logic [6:0] ASCII_DASH = 7'h2D;
  localparam logic [6:0] ASCII_A    = 7'h41;
  localparam logic [6:0] ASCII_Z    = 7'h5A;

  typedef logic [6:0] ascii_t;
  typedef logic [WORD_LEN-1:0][6:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    EVAL,
    WIN,
    LOSE
  } state_e;

  function automatic logic is_letter(input ascii_t c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_if.sv
// rtl/hangman_game_ctrl_if.sv - guess handshake between the player and the game controller
interface hangman_game_ctrl_if;
  logic       guess_valid;
  logic [6:0] guess_letter;
  logic       guess_ready;

  modport master (
    output guess_valid,
    output guess_letter,
    input  guess_ready
  );

  modport slave (
    input  guess_valid,
    input  guess_letter,
    output guess_ready
  );
endinterface

// File: rtl/hangman_letter_match.sv
// rtl/hangman_letter_match.sv - parallel compare of one guess against every word position
module hangman_letter_match
  import hangman_pkg::*;
(
  input  word_t                letters_i,
  input  ascii_t               guess_i,
  output logic [WORD_LEN-1:0]  match_o
);

  always_comb begin
    match_o = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      match_o[i] = (letters_i[i] == guess_i);
    end
  end

endmodule

// File: rtl/hangman_game_ctrl.sv
// rtl/hangman_game_ctrl.sv - hangman game FSM: latch word, evaluate guesses, track reveals and misses
// Optional repeated-letter rejection is enabled by HANGMAN_REPEAT_DETECT_EN.
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int MAX_MISSES = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [6:0]           word_1,
  input  logic [6:0]           word_2,
  input  logic [6:0]           word_3,
  input  logic [6:0]           word_4,
  input  logic [6:0]           word_5,
  input  logic [6:0]           word_6,
  input  logic [6:0]           word_7,
  hangman_game_ctrl_if.slave   guess,
  output logic [6:0]           out_ascii_1,
  output logic [6:0]           out_ascii_2,
  output logic [6:0]           out_ascii_3,
  output logic [6:0]           out_ascii_4,
  output logic [6:0]           out_ascii_5,
  output logic [6:0]           out_ascii_6,
  output logic [6:0]           out_ascii_7,
  output logic [WORD_LEN-1:0]  reveal_mask,
  output logic [2:0]           miss_count,
  output logic                 hit,
  output logic                 miss,
  output logic                 guess_err,
  output logic                 win,
  output logic                 lose
);

  localparam logic [2:0] MAX_M = 3'(MAX_MISSES);

  state_e               state_q, state_d;
  word_t                word_q, word_d;
  word_t                out_q, out_d;
  ascii_t               guess_q, guess_d;
  logic [WORD_LEN-1:0]  mask_q, mask_d;
  logic [2:0]           miss_q, miss_d;
  logic                 hit_q, hit_d;
  logic                 miss_p_q, miss_p_d;
  logic                 err_q, err_d;
  logic                 win_q, win_d;
  logic                 lose_q, lose_d;
  logic [WORD_LEN-1:0]  match;

`ifdef HANGMAN_REPEAT_DETECT_EN
  logic [25:0]          seen_q, seen_d;
  logic [4:0]           letter_idx;

  assign letter_idx = 5'(guess_q - ASCII_A);
`endif

  hangman_letter_match u_match (
    .letters_i (word_q),
    .guess_i   (guess_q),
    .match_o   (match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      out_q    <= {WORD_LEN{ASCII_DASH}};
      guess_q  <= '0;
      mask_q   <= '0;
      miss_q   <= '0;
      hit_q    <= 1'b0;
      miss_p_q <= 1'b0;
      err_q    <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
`ifdef HANGMAN_REPEAT_DETECT_EN
      seen_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      out_q    <= out_d;
      guess_q  <= guess_d;
      mask_q   <= mask_d;
      miss_q   <= miss_d;
      hit_q    <= hit_d;
      miss_p_q <= miss_p_d;
      err_q    <= err_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
`ifdef HANGMAN_REPEAT_DETECT_EN
      seen_q   <= seen_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    guess_d  = guess_q;
    mask_d   = mask_q;
    miss_d   = miss_q;
    hit_d    = 1'b0;
    miss_p_d = 1'b0;
    err_d    = 1'b0;
    win_d    = win_q;
    lose_d   = lose_q;
`ifdef HANGMAN_REPEAT_DETECT_EN
    seen_d   = seen_q;
`endif

    // start aborts whatever is in flight, including a pending EVAL
    if (start) begin
      state_d = PLAY;
      word_d  = {word_7, word_6, word_5, word_4, word_3, word_2, word_1};
      mask_d  = '0;
      miss_d  = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
`ifdef HANGMAN_REPEAT_DETECT_EN
      seen_d  = '0;
`endif
    end else begin
      case (state_q)
        PLAY: begin
          if (guess.guess_valid) begin
            guess_d = guess.guess_letter;
            state_d = EVAL;
          end
        end
        EVAL: begin
          if (!is_letter(guess_q)) begin
            err_d = 1'b1;
          end
`ifdef HANGMAN_REPEAT_DETECT_EN
          else if (seen_q[letter_idx]) begin
            err_d = 1'b1;
          end
`endif
          else begin
            if (|match) begin
              hit_d  = 1'b1;
              mask_d = mask_q | match;
            end else begin
              miss_p_d = 1'b1;
              if (miss_q != MAX_M) begin
                miss_d = miss_q + 3'd1;
              end
            end
`ifdef HANGMAN_REPEAT_DETECT_EN
            seen_d[letter_idx] = 1'b1;
`endif
          end

          // a full reveal wins even if the miss limit was reached in the same step
          if (mask_d == '1) begin
            state_d = WIN;
            win_d   = 1'b1;
          end else if (miss_d == MAX_M) begin
            state_d = LOSE;
            lose_d  = 1'b1;
          end else begin
            state_d = PLAY;
          end
        end
        default: ;
      endcase
    end

    out_d = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      out_d[i] = mask_d[i] ? word_d[i] : ASCII_DASH;
    end
  end

  assign guess.guess_ready = (state_q == PLAY);

  assign out_ascii_1 = out_q[0];
  assign out_ascii_2 = out_q[1];
  assign out_ascii_3 = out_q[2];
  assign out_ascii_4 = out_q[3];
  assign out_ascii_5 = out_q[4];
  assign out_ascii_6 = out_q[5];
  assign out_ascii_7 = out_q[6];

  assign reveal_mask = mask_q;
  assign miss_count  = miss_q;
  assign hit         = hit_q;
  assign miss        = miss_p_q;
  assign guess_err   = err_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// tb/tb_hangman_game_ctrl.sv - table, directed and random checks of hangman_game_ctrl against a game model
module tb_hangman_game_ctrl;

  localparam int MAXM = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] tb_word [7];
  logic [6:0] out_a [7];
  logic [6:0] reveal_mask;
  logic [2:0] miss_count;
  logic       hit, miss, guess_err, win, lose;

  int vectors = 0;
  int miscompares = 0;

  hangman_game_ctrl_if gif ();

  always #5 clk = ~clk;

  hangman_game_ctrl #(.MAX_MISSES(MAXM)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .word_1      (tb_word[0]),
    .word_2      (tb_word[1]),
    .word_3      (tb_word[2]),
    .word_4      (tb_word[3]),
    .word_5      (tb_word[4]),
    .word_6      (tb_word[5]),
    .word_7      (tb_word[6]),
    .guess       (gif),
    .out_ascii_1 (out_a[0]),
    .out_ascii_2 (out_a[1]),
    .out_ascii_3 (out_a[2]),
    .out_ascii_4 (out_a[3]),
    .out_ascii_5 (out_a[4]),
    .out_ascii_6 (out_a[5]),
    .out_ascii_7 (out_a[6]),
    .reveal_mask (reveal_mask),
    .miss_count  (miss_count),
    .hit         (hit),
    .miss        (miss),
    .guess_err   (guess_err),
    .win         (win),
    .lose        (lose)
  );

  // game model: 0 idle, 1 playing, 2 won, 3 lost
  int         m_state;
  int         m_miss;
  logic [6:0] m_w [7];
  bit         m_rev [7];
  bit         m_hit, m_misp, m_err;
  bit         m_seen [26];

  typedef struct {
    bit         do_start;
    logic [6:0] letter;
    bit         e_hit, e_miss, e_err;
    logic [6:0] e_mask;
    logic [2:0] e_misses;
    bit         e_win, e_lose;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_miss  = 0;
    m_hit = 0; m_misp = 0; m_err = 0;
    for (int i = 0; i < 7; i++) m_rev[i] = 0;
    for (int i = 0; i < 26; i++) m_seen[i] = 0;
  endtask

  task automatic model_start();
    model_reset();
    m_state = 1;
    for (int i = 0; i < 7; i++) m_w[i] = tb_word[i];
  endtask

  task automatic model_guess(input logic [6:0] c);
    bit any;
    bit all_rev;
    m_hit = 0; m_misp = 0; m_err = 0;
    if (m_state != 1) return;
    if (c < 7'h41 || c > 7'h5A) begin
      m_err = 1;
      return;
    end
`ifdef HANGMAN_REPEAT_DETECT_EN
    if (m_seen[int'(c) - 65]) begin
      m_err = 1;
      return;
    end
    m_seen[int'(c) - 65] = 1;
`endif
    any = 0;
    for (int i = 0; i < 7; i++) begin
      if (m_w[i] == c) begin
        m_rev[i] = 1;
        any = 1;
      end
    end
    if (any) m_hit = 1;
    else begin
      m_misp = 1;
      if (m_miss < MAXM) m_miss++;
    end
    all_rev = 1;
    for (int i = 0; i < 7; i++) if (!m_rev[i]) all_rev = 0;
    if (all_rev) m_state = 2;
    else if (m_miss == MAXM) m_state = 3;
  endtask

  task automatic check_all(input string tag);
    logic [6:0] em;
    em = '0;
    for (int i = 0; i < 7; i++) em[i] = m_rev[i];
    chk({tag, ":mask"}, 32'(reveal_mask), 32'(em));
    chk({tag, ":misses"}, 32'(miss_count), 32'(m_miss));
    chk({tag, ":hit"}, 32'(hit), 32'(m_hit));
    chk({tag, ":miss"}, 32'(miss), 32'(m_misp));
    chk({tag, ":err"}, 32'(guess_err), 32'(m_err));
    chk({tag, ":win"}, 32'(win), 32'(m_state == 2));
    chk({tag, ":lose"}, 32'(lose), 32'(m_state == 3));
    chk({tag, ":ready"}, 32'(gif.guess_ready), 32'(m_state == 1));
    for (int i = 0; i < 7; i++)
      chk({tag, ":out"}, 32'(out_a[i]), 32'(m_rev[i] ? m_w[i] : 7'h2D));
  endtask

  task automatic set_word(input string s);
    for (int i = 0; i < 7; i++) tb_word[i] = 7'(s[i]);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_start();
  endtask

  // leaves the sampling point one cycle after the EVAL edge
  task automatic drive_guess(input logic [6:0] c);
    @(negedge clk);
    gif.guess_valid  = 1'b1;
    gif.guess_letter = c;
    @(negedge clk);
    gif.guess_valid  = 1'b0;
    @(negedge clk);
  endtask

  task automatic guess_chk(input logic [6:0] c, input string tag);
    drive_guess(c);
    model_guess(c);
    check_all(tag);
    @(negedge clk);
    chk({tag, ":pulse_clr"}, 32'({hit, miss, guess_err}), 32'(0));
    m_hit = 0; m_misp = 0; m_err = 0;
  endtask

  initial begin
    for (int i = 0; i < 7; i++) tb_word[i] = '0;
    gif.guess_valid  = 1'b0;
    gif.guess_letter = '0;

    tbl[0]  = '{1, 7'h41, 1, 0, 0, 7'h22, 3'd0, 0, 0};
    tbl[1]  = '{1, 7'h48, 1, 0, 0, 7'h01, 3'd0, 0, 0};
    tbl[2]  = '{0, 7'h4E, 1, 0, 0, 7'h45, 3'd0, 0, 0};
    tbl[3]  = '{0, 7'h47, 1, 0, 0, 7'h4D, 3'd0, 0, 0};
    tbl[4]  = '{0, 7'h4D, 1, 0, 0, 7'h5D, 3'd0, 0, 0};
    tbl[5]  = '{0, 7'h41, 1, 0, 0, 7'h7F, 3'd0, 1, 0};
    tbl[6]  = '{1, 7'h61, 0, 0, 1, 7'h00, 3'd0, 0, 0};
    tbl[7]  = '{0, 7'h42, 0, 1, 0, 7'h00, 3'd1, 0, 0};
    tbl[8]  = '{0, 7'h43, 0, 1, 0, 7'h00, 3'd2, 0, 0};
    tbl[9]  = '{0, 7'h44, 0, 1, 0, 7'h00, 3'd3, 0, 0};
    tbl[10] = '{0, 7'h45, 0, 1, 0, 7'h00, 3'd4, 0, 0};
    tbl[11] = '{0, 7'h46, 0, 1, 0, 7'h00, 3'd5, 0, 0};
    tbl[12] = '{0, 7'h49, 0, 1, 0, 7'h00, 3'd6, 0, 1};
    tbl[13] = '{0, 7'h48, 0, 0, 0, 7'h00, 3'd6, 0, 1};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("reset");

    for (int k = 0; k < 14; k++) begin
      if (tbl[k].do_start) begin
        set_word("HANGMAN");
        do_start();
      end
      drive_guess(tbl[k].letter);
      chk("tbl_hit", 32'(hit), 32'(tbl[k].e_hit));
      chk("tbl_miss", 32'(miss), 32'(tbl[k].e_miss));
      chk("tbl_err", 32'(guess_err), 32'(tbl[k].e_err));
      chk("tbl_mask", 32'(reveal_mask), 32'(tbl[k].e_mask));
      chk("tbl_misses", 32'(miss_count), 32'(tbl[k].e_misses));
      chk("tbl_win", 32'(win), 32'(tbl[k].e_win));
      chk("tbl_lose", 32'(lose), 32'(tbl[k].e_lose));
      chk("tbl_ready", 32'(gif.guess_ready), 32'(!(tbl[k].e_win || tbl[k].e_lose)));
      for (int i = 0; i < 7; i++)
        chk("tbl_out", 32'(out_a[i]), 32'(tbl[k].e_mask[i] ? tb_word[i] : 7'h2D));
    end

    // five misses then the last hidden letter wins
    set_word("AAAAAAB");
    do_start();
    guess_chk(7'h41, "late_win_a");
    guess_chk(7'h43, "late_win_m1");
    guess_chk(7'h44, "late_win_m2");
    guess_chk(7'h45, "late_win_m3");
    guess_chk(7'h46, "late_win_m4");
    guess_chk(7'h47, "late_win_m5");
    guess_chk(7'h42, "late_win_b");
    chk("late_win_win", 32'(win), 32'(1));
    chk("late_win_lose", 32'(lose), 32'(0));

    // repeated letter: rejected only when repeat detection is built in
    set_word("HANGMAN");
    do_start();
    guess_chk(7'h51, "repeat_q1");
    guess_chk(7'h51, "repeat_q2");
    guess_chk(7'h41, "repeat_a1");
    guess_chk(7'h41, "repeat_a2");

    // rst during EVAL
    set_word("HANGMAN");
    do_start();
    @(negedge clk);
    gif.guess_valid = 1'b1; gif.guess_letter = 7'h41;
    @(negedge clk);
    gif.guess_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("rst_in_eval");

    // rst wins over start
    set_word("ZEBRAXY");
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    model_reset();
    check_all("rst_over_start");

    // start during EVAL aborts the guess and loads the new word
    set_word("HANGMAN");
    do_start();
    guess_chk(7'h41, "pre_abort");
    @(negedge clk);
    gif.guess_valid = 1'b1; gif.guess_letter = 7'h4E;
    @(negedge clk);
    gif.guess_valid = 1'b0;
    set_word("ZEBRAXY");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_start();
    check_all("start_in_eval");
    guess_chk(7'h5A, "post_abort_z");

    // random games
    for (int g = 0; g < 300; g++) begin
      logic [6:0] c;
      if (m_state != 1 || $urandom_range(0, 29) == 0) begin
        for (int i = 0; i < 7; i++)
          tb_word[i] = ($urandom_range(0, 9) == 0) ? 7'h31 : 7'(65 + $urandom_range(0, 9));
        do_start();
        check_all("rnd_start");
      end
      if ($urandom_range(0, 9) == 0) c = 7'($urandom_range(0, 127));
      else c = 7'(65 + $urandom_range(0, 9));
      guess_chk(c, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
